// File: rtl/apb_master_pkg.sv
// Shared constants for the APB command master: FSM state encodings,
// APB phase encodings and a small counter helper.
package apb_master_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // APB phase as {PSEL, PENABLE}
  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_SETUP  = 2'b10;
  localparam logic [1:0] PH_ACCESS = 2'b11;

  localparam int unsigned WAIT_CNT_W = 8;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB3 bridge: one command in, one APB transfer,
// one response out, with an optional ACCESS-phase wait timeout.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);
  localparam bit                    TIMEOUT_EN  = (TIMEOUT != 0);

  logic [1:0]            state_reg;
  logic                  cmd_ready_reg;
  logic                  psel_reg;
  logic                  penable_reg;
  logic                  pwrite_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic                  rsp_timeout_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;

  logic cmd_fire;
  assign cmd_fire = cmd_ready_reg & CMD_VALID;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_reg       <= ST_IDLE;
      cmd_ready_reg   <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // CMD_READY comes up on the first edge after reset and stays up until a command lands
          cmd_ready_reg <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_reg            <= 1'b0;
            paddr_reg                <= CMD_ADDR;
            pwrite_reg               <= CMD_WRITE;
            pwdata_reg               <= CMD_WDATA;
            {psel_reg, penable_reg}  <= PH_SETUP;
            wait_cnt_reg             <= '0;
            state_reg                <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          {psel_reg, penable_reg} <= PH_ACCESS;
          state_reg               <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            rsp_rdata_reg           <= pwrite_reg ? '0 : PRDATA;
            rsp_err_reg             <= PSLVERR;
            rsp_timeout_reg         <= 1'b0;
            rsp_valid_reg           <= 1'b1;
            {psel_reg, penable_reg} <= PH_IDLE;
            state_reg               <= ST_RESP;
          end else if (TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_CNT)) begin
            // Abandon the slave: drop the bus and report a timed-out error
            rsp_rdata_reg           <= '0;
            rsp_err_reg             <= 1'b1;
            rsp_timeout_reg         <= 1'b1;
            rsp_valid_reg           <= 1'b1;
            {psel_reg, penable_reg} <= PH_IDLE;
            state_reg               <= ST_RESP;
          end else begin
            wait_cnt_reg <= sat_inc(wait_cnt_reg);
          end
        end

        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg               <= ST_IDLE;
          {psel_reg, penable_reg} <= PH_IDLE;
          rsp_valid_reg           <= 1'b0;
          cmd_ready_reg           <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY   = cmd_ready_reg;
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PWRITE      = pwrite_reg;
  assign PADDR       = paddr_reg;
  assign PWDATA      = pwdata_reg;
  assign RSP_VALID   = rsp_valid_reg;
  assign RSP_RDATA   = rsp_rdata_reg;
  assign RSP_ERR     = rsp_err_reg;
  assign RSP_TIMEOUT = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: vector table of APB transfers plus a
// hand-written reset-during-ACCESS sequence, with a response scoreboard.
module tb_apb_cmd_master;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_WDATA;
  logic          RSP_VALID, RSP_READY;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR, RSP_TIMEOUT;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;      // ACCESS cycles with PREADY=0 before PREADY=1
    logic [DW-1:0] prdata;
    logic          slverr;
    int            rsp_delay;  // cycles RSP_READY is held low
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bit   timed_out;
    int   exp_access;
    int   guard;
    int   acc;
    bit   stable;
    rsp_t e;
    rsp_t got;

    timed_out  = (v.waits > TMO);
    exp_access = timed_out ? TMO + 1 : v.waits + 1;

    CMD_VALID = 1'b1;
    CMD_WRITE = v.wr;
    CMD_ADDR  = v.addr;
    CMD_WDATA = v.wdata;
    guard = 0;
    while (CMD_READY !== 1'b1 && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    chk({tag, " cmd_ready_idle"}, CMD_READY, 1);

    @(posedge PCLK);
    e.rdata = (v.wr || timed_out) ? '0 : v.prdata;
    e.err   = timed_out | v.slverr;
    e.tmo   = timed_out;
    sb_q.push_back(e);

    // SETUP: scramble CMD_* and drive misleading slave signals, all to be ignored
    @(negedge PCLK);
    CMD_WRITE = ~v.wr;
    CMD_ADDR  = ~v.addr;
    CMD_WDATA = ~v.wdata;
    PREADY    = 1'b1;
    PSLVERR   = 1'b1;
    PRDATA    = 8'hA5;
    chk({tag, " setup_phase"}, {PSEL, PENABLE, CMD_READY}, 3'b100);
    chk({tag, " paddr"},  PADDR,  v.addr);
    chk({tag, " pwrite"}, PWRITE, v.wr);
    chk({tag, " pwdata"}, PWDATA, v.wdata);

    @(negedge PCLK);
    chk({tag, " access_phase"}, {PSEL, PENABLE}, 2'b11);
    acc     = 1;
    PREADY  = (v.waits == 0);
    PSLVERR = v.slverr;
    PRDATA  = v.prdata;
    stable  = 1'b1;
    guard   = 0;
    while (guard < 300) begin
      @(negedge PCLK);
      guard++;
      if (PENABLE !== 1'b1) break;
      if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata || PSEL !== 1'b1) stable = 1'b0;
      acc++;
      PREADY = (acc - 1 == v.waits);
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    chk({tag, " access_addr_stable"}, stable, 1);
    chk({tag, " access_cycles"}, acc, exp_access);
    chk({tag, " resp_phase"}, {RSP_VALID, PSEL, PENABLE}, 3'b100);

    got.rdata = RSP_RDATA;
    got.err   = RSP_ERR;
    got.tmo   = RSP_TIMEOUT;
    RSP_READY = 1'b0;
    CMD_VALID = 1'b1;
    stable    = 1'b1;
    for (int i = 0; i < v.rsp_delay; i++) begin
      @(negedge PCLK);
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== got.rdata || RSP_ERR !== got.err ||
          RSP_TIMEOUT !== got.tmo || CMD_READY !== 1'b0 || PSEL !== 1'b0) stable = 1'b0;
    end
    chk({tag, " resp_hold_stable"}, stable, 1);

    RSP_READY = 1'b1;
    CMD_VALID = 1'b0;
    @(posedge PCLK);
    chk({tag, " scoreboard_nonempty"}, (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, " rsp_rdata"},   got.rdata, e.rdata);
      chk({tag, " rsp_err"},     got.err,   e.err);
      chk({tag, " rsp_timeout"}, got.tmo,   e.tmo);
    end

    @(negedge PCLK);
    RSP_READY = 1'b0;
    chk({tag, " after_handshake"}, {RSP_VALID, CMD_READY}, 2'b01);
    $display("txn %s: wr=%0d addr=0x%0h wdata=0x%0h access=%0d rdata=0x%0h err=%0d tmo=%0d",
             tag, v.wr, v.addr, v.wdata, acc, got.rdata, got.err, got.tmo);
  endtask

  vec_t vecs[7];
  vec_t vr;
  bit   quiet;

  initial begin
    PRESETN   = 1'b0;
    CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
    RSP_READY = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    //           wr    addr    wdata  waits prdata slverr delay
    vecs[0] = '{1'b1, 5'h08, 8'h1A, 0,   8'hFF, 1'b0, 0};
    vecs[1] = '{1'b0, 5'h10, 8'h00, 3,   8'h05, 1'b0, 0};
    vecs[2] = '{1'b1, 5'h03, 8'h5C, 0,   8'h00, 1'b1, 1};
    vecs[3] = '{1'b0, 5'h1F, 8'h00, 255, 8'hEE, 1'b0, 0};
    vecs[4] = '{1'b0, 5'h04, 8'h00, 0,   8'h3C, 1'b0, 10};
    vecs[5] = '{1'b0, 5'h15, 8'h00, 4,   8'h77, 1'b1, 0};
    vecs[6] = '{1'b1, 5'h0A, 8'hC3, 1,   8'h99, 1'b0, 2};

    repeat (2) @(negedge PCLK);
    chk("reset_outputs",
        {CMD_READY, PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT}, 7'b0);
    chk("reset_buses", {PADDR, PWDATA, RSP_RDATA}, 0);
    PRESETN = 1'b1;
    chk("cmd_ready_before_first_edge", CMD_READY, 0);
    @(negedge PCLK);
    chk("cmd_ready_after_first_edge", CMD_READY, 1);

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("v%0d", i));

    // Reset pulse while the slave is stalling in ACCESS
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 5'h11; CMD_WDATA = 8'h00;
    @(posedge PCLK);
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    @(negedge PCLK);
    chk("rst_seq in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETN = 1'b0;
    #1;
    chk("rst_seq async_clear", {PSEL, PENABLE, RSP_VALID, CMD_READY}, 4'b0);
    chk("rst_seq paddr_clear", PADDR, 0);
    @(negedge PCLK);
    PRESETN = 1'b1;
    quiet   = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      if (RSP_VALID !== 1'b0 || PSEL !== 1'b0) quiet = 1'b0;
    end
    chk("rst_seq no_response", quiet, 1);
    chk("rst_seq cmd_ready", CMD_READY, 1);
    chk("rst_seq scoreboard_empty", sb_q.size(), 0);
    vr = '{1'b0, 5'h12, 8'h00, 2, 8'h6B, 1'b0, 0};
    run_txn(vr, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5: APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: maximum ACCESS-phase wait cycles (0 = timeout disabled); it SHALL be held in an 8-bit counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- PCLK  in  1  system clock
- PRESETN  in  1  asynchronous active-low reset
REQ-005 The block SHALL have these command ports:
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when high with CMD_VALID
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_WIDTH  target address
- CMD_WDATA  in  DATA_WIDTH  write data
REQ-006 The block SHALL have these response ports:
- RSP_VALID  out  1  response available
- RSP_READY  in  1  response consumed
- RSP_RDATA  out  DATA_WIDTH  read data, 0 for writes
- RSP_ERR  out  1  PSLVERR seen or timeout
- RSP_TIMEOUT  out  1  transfer aborted by timeout
REQ-007 The block SHALL have these APB3 master ports:
- PADDR  out  ADDR_WIDTH
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH
- PREADY  in  1
- PSLVERR  in  1

Function
REQ-008 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP; every APB and RSP output SHALL be driven from a register.
REQ-009 CMD_READY SHALL be high only in IDLE, and a command SHALL be accepted on the edge where CMD_VALID and CMD_READY are both high.
REQ-010 On acceptance, CMD_ADDR, CMD_WRITE and CMD_WDATA SHALL be captured into PADDR, PWRITE and PWDATA, and the FSM SHALL move IDLE->SETUP.
REQ-011 In SETUP, PSEL SHALL be 1 and PENABLE 0; the next state SHALL always be ACCESS.
REQ-012 In ACCESS, PSEL SHALL be 1 and PENABLE 1; the FSM SHALL remain in ACCESS while PREADY=0 and the wait counter is below TIMEOUT.
REQ-013 On PREADY=1 in ACCESS:
- RSP_RDATA SHALL capture PRDATA for reads and 0 for writes.
- RSP_ERR SHALL capture PSLVERR, and RSP_TIMEOUT SHALL be 0.
- The FSM SHALL go to RESP.
REQ-014 The wait counter SHALL clear on entry to SETUP, increment each ACCESS cycle with PREADY=0, and saturate at 255.
REQ-015 When TIMEOUT!=0 and the counter equals TIMEOUT with PREADY=0:
- PSEL and PENABLE SHALL drop.
- RSP_ERR and RSP_TIMEOUT SHALL be 1, and RSP_RDATA 0.
- The FSM SHALL go to RESP.
REQ-016 In RESP:
- RSP_VALID SHALL be 1 and PSEL/PENABLE 0.
- RSP_* SHALL stay stable until RSP_READY=1, then the FSM SHALL go to IDLE and RSP_VALID SHALL clear.
REQ-017 With zero wait states, latency from the acceptance edge SHALL be:
- SETUP on cycle 1
- ACCESS on cycle 2
- RSP_VALID on cycle 3
- CMD_READY again one cycle after the RSP handshake
REQ-018 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS, and SHALL hold their last value in IDLE/RESP.
REQ-019 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-020 CMD_* changes while not in IDLE SHALL have no effect.

Reset
REQ-021 Asserting PRESETN low SHALL, immediately and asynchronously:
- force IDLE
- clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT and the counter
- set CMD_READY to 1 from the first edge after release
REQ-022 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abort the transfer with no response issued.

Structure
REQ-023 State encodings and the APB phase constants SHALL live in the shared package apb_master_pkg.
REQ-024 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Write addr 0x08, data 0x1A, PREADY=1: PSEL on cycle 1, PENABLE on cycle 2, RSP_VALID on cycle 3 with ERR=0 and RDATA=0x00.
- Read addr 0x10, PREADY low for 3 cycles, PRDATA=0x05: ACCESS lasts 4 cycles, RSP_RDATA=0x05, ERR=0.
- Write with PSLVERR=1 on the PREADY cycle: RSP_ERR=1, RSP_TIMEOUT=0.
- TIMEOUT=4, PREADY held 0: PSEL drops after 4 wait cycles; RSP_ERR=1, RSP_TIMEOUT=1, RDATA=0x00.
- RSP_READY held low 10 cycles then high: RSP fields stable throughout; CMD_READY rises the cycle after the handshake; CMD_VALID held high meanwhile is not accepted.
- PRESETN pulsed low during ACCESS: PSEL/PENABLE=0 immediately; no RSP_VALID; a new command is accepted normally after release.
